// File: rtl/ip_panel_rx.sv
// ip_panel_rx: receive side of the indicator-panel serial link.
//
// Emulates the panel board's shift-register chain. The ip_clk/ip_latch/ip_out
// wire stream is oversampled on clk20 through synchronizers and deserialized
// into a parallel lamp image. Each frame is qualified by its bit count, and
// loss of the panel clock is reported on link_up.
//
// Ports:
//   clk20        in   20 MHz system clock (the only clock)
//   reset        in   asynchronous, active-high reset
//   ip_clk       in   panel shift clock, wire level; data taken on its rise
//   ip_latch     in   panel latch, active low on the wire; marks last bit
//   ip_out       in   panel serial data, inverted on the wire (0 = lamp on)
//   lamps        out  last good frame, first received bit in the MSB
//   frame_strobe out  one-cycle pulse when lamps is updated
//   frame_err    out  sticky bad-length flag, cleared by the next good frame
//   link_up      out  high while ip_clk rises arrive within TIMEOUT cycles
//   bit_count    out  bits received in the current frame (debug)

module ip_panel_rx #(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned ROW_BITS    = 36,
  parameter int unsigned SYNC_STAGES = 2,     // must be at least 2
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                                   clk20,
  input  logic                                   reset,
  input  logic                                   ip_clk,
  input  logic                                   ip_latch,
  input  logic                                   ip_out,
  output logic [ROWS*ROW_BITS-1:0]               lamps,
  output logic                                   frame_strobe,
  output logic                                   frame_err,
  output logic                                   link_up,
  output logic [$clog2(ROWS*ROW_BITS+2)-1:0]     bit_count
);

  localparam int unsigned TOTAL = ROWS * ROW_BITS;
  localparam int unsigned CntW  = $clog2(TOTAL + 2);
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

  // bit_count value seen on the latch sample of a correctly sized frame
  localparam logic [CntW-1:0] LastIdx = CntW'(TOTAL - 1);
  // Saturation value marking an overrun frame
  localparam logic [CntW-1:0] Overrun = CntW'(TOTAL + 1);
  localparam logic [ToW-1:0]  ToMax   = ToW'(TIMEOUT);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] out_sync_q;
  logic                   clk_dly_q;

  logic clk_synced;
  logic sample;
  logic rx_bit;
  logic rx_last;

  // Preset to the idle wire level so leaving reset never looks like a rise.
  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      clk_sync_q   <= '1;
      latch_sync_q <= '1;
      out_sync_q   <= '1;
      clk_dly_q    <= 1'b1;
    end else begin
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ip_clk};
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], ip_latch};
      out_sync_q   <= {out_sync_q[SYNC_STAGES-2:0], ip_out};
      clk_dly_q    <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_synced = clk_sync_q[SYNC_STAGES-1];
  // Single-cycle pulse per synchronized rise: one shift per panel clock.
  assign sample     = clk_synced & ~clk_dly_q;
  // Data and latch share the clock's synchronizer depth, so they line up
  // with the sample pulse.
  assign rx_bit     = ~out_sync_q[SYNC_STAGES-1];
  assign rx_last    = ~latch_sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Frame assembly state
  // --------------------------------------------------------------------------
  logic [TOTAL-1:0] shift_q,   shift_d;
  logic [TOTAL-1:0] lamps_q,   lamps_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ToW-1:0]   to_cnt_q,  to_cnt_d;
  logic             pend_q,    pend_d;
  logic             strobe_q,  strobe_d;
  logic             err_q,     err_d;
  logic             link_q,    link_d;

  always_comb begin
    shift_d   = shift_q;
    lamps_d   = lamps_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    pend_d    = 1'b0;
    strobe_d  = 1'b0;
    err_d     = err_q;
    link_d    = link_q;

    // A good frame was closed last cycle: shift_q now holds the final bit.
    if (pend_q) begin
      lamps_d  = shift_q;
      strobe_d = 1'b1;
      err_d    = 1'b0;
    end

    if (sample) begin
      shift_d  = {shift_q[TOTAL-2:0], rx_bit};
      to_cnt_d = '0;
      link_d   = 1'b1;
      if (!rx_last) begin
        if (bit_cnt_q != Overrun) begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end else begin
        bit_cnt_d = '0;
        if (bit_cnt_q == LastIdx) begin
          pend_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      if (to_cnt_q != ToMax) begin
        to_cnt_d = to_cnt_q + ToW'(1);
      end
      // Link lost: drop the partial frame, keep the stale lamp image.
      if (to_cnt_d == ToMax) begin
        link_d    = 1'b0;
        bit_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      lamps_q   <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      pend_q    <= 1'b0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
      link_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      lamps_q   <= lamps_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      pend_q    <= pend_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
      link_q    <= link_d;
    end
  end

  assign lamps        = lamps_q;
  assign frame_strobe = strobe_q;
  assign frame_err    = err_q;
  assign link_up      = link_q;
  assign bit_count    = bit_cnt_q;

endmodule
